// File: rtl/muldiv_pkg.sv
// Shared constants for the multi-cycle multiply/divide unit: ALU function codes,
// FSM state encoding and the default datapath width.
package muldiv_pkg;

   localparam int unsigned DEFAULT_WIDTH = 32;

   localparam logic [5:0] ED_MFHI  = 6'b010000;
   localparam logic [5:0] ED_MTHI  = 6'b010001;
   localparam logic [5:0] ED_MFLO  = 6'b010010;
   localparam logic [5:0] ED_MTLO  = 6'b010011;
   localparam logic [5:0] ED_MULT  = 6'b011000;
   localparam logic [5:0] ED_MULTU = 6'b011001;
   localparam logic [5:0] ED_DIV   = 6'b011010;
   localparam logic [5:0] ED_DIVU  = 6'b011011;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StCalc = 2'd1;
   localparam logic [1:0] StFix  = 2'd2;

endpackage

// File: rtl/muldiv_iter.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// Multiply accumulator is {partial_hi, multiplier}; divide accumulator is {remainder, quotient}.
module muldiv_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               is_div,
   input  logic [2*WIDTH-1:0] acc_in,
   input  logic [WIDTH-1:0]   operand,
   output logic [2*WIDTH-1:0] acc_out
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   upper;
   logic [WIDTH+1:0] diff;

   always_comb begin
      sum   = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
      upper = acc_in[2*WIDTH-1:WIDTH-1];
      // Extra guard bit keeps the compare correct even when the divisor is zero.
      diff  = {1'b0, upper} - {2'b00, operand};
      if (is_div) begin
         if (!diff[WIDTH+1]) begin
            acc_out = {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
         end else begin
            acc_out = {upper[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_out = {sum, acc_in[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; magnitudes are iterated unsigned and
// signs are applied in a final fix-up cycle.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned ITERS = WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [5:0]       ed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CntW = (ITERS > 1) ? $clog2(ITERS) : 1;

   logic [1:0]         state_q, state_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d, acc_nxt;
   logic [WIDTH-1:0]   op_q, op_d;
   logic               is_div_q, is_div_d;
   logic               neg_q, neg_d;
   logic               sa_q, sa_d;
   logic               bz_q, bz_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               done_q, done_d;
   logic               dz_q, dz_d;

   logic               op_signed, op_div, a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag, q_mag, r_mag;
   logic [2*WIDTH-1:0] prod;

   muldiv_iter #(
      .WIDTH (WIDTH)
   ) u_iter (
      .is_div  (is_div_q),
      .acc_in  (acc_q),
      .operand (op_q),
      .acc_out (acc_nxt)
   );

   always_comb begin
      op_signed = (ed == ED_MULT) || (ed == ED_DIV);
      op_div    = (ed == ED_DIV) || (ed == ED_DIVU);
      a_neg     = op_signed && a[WIDTH-1];
      b_neg     = op_signed && b[WIDTH-1];
      a_mag     = a_neg ? -a : a;
      b_mag     = b_neg ? -b : b;
      prod      = neg_q ? -acc_q : acc_q;
      q_mag     = acc_q[WIDTH-1:0];
      r_mag     = acc_q[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      op_d     = op_q;
      is_div_d = is_div_q;
      neg_d    = neg_q;
      sa_d     = sa_q;
      bz_d     = bz_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      dz_d     = dz_q;
      case (state_q)
         StIdle: begin
            if (req_valid) begin
               case (ed)
                  ED_MULT, ED_MULTU, ED_DIV, ED_DIVU: begin
                     is_div_d = op_div;
                     neg_d    = a_neg ^ b_neg;
                     sa_d     = a_neg;
                     bz_d     = op_div && (b == '0);
                     // Divide iterates over the dividend, multiply over the multiplier.
                     acc_d    = op_div ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                     op_d     = op_div ? b_mag : a_mag;
                     cnt_d    = '0;
                     dz_d     = 1'b0;
                     state_d  = StCalc;
                  end
                  ED_MTHI: hi_d = a;
                  ED_MTLO: lo_d = a;
                  default: ;
               endcase
            end
         end
         StCalc: begin
            acc_d = acc_nxt;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntW'(ITERS - 1)) begin
               state_d = StFix;
            end
         end
         StFix: begin
            if (is_div_q) begin
               lo_d = bz_q ? '1 : (neg_q ? -q_mag : q_mag);
               hi_d = sa_q ? -r_mag : r_mag;
               dz_d = bz_q;
            end else begin
               {hi_d, lo_d} = prod;
            end
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         acc_q    <= '0;
         op_q     <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         sa_q     <= 1'b0;
         bz_q     <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         op_q     <= op_d;
         is_div_q <= is_div_d;
         neg_q    <= neg_d;
         sa_q     <= sa_d;
         bz_q     <= bz_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
         dz_q     <= dz_d;
      end
   end

   assign req_ready = (state_q == StIdle);
   assign busy      = (state_q != StIdle);
   assign done      = done_q;
   assign div_zero  = dz_q;
   assign hi        = hi_q;
   assign lo        = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed HI/LO results.
module tb_muldiv_unit;

   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MTLO  = 6'b010011;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [5:0]  ed = '0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;

   int n_checks = 0;
   int n_fail   = 0;

   muldiv_unit #(
      .WIDTH (32),
      .ITERS (32)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .ed        (ed),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Presents a request at the falling edge; it is accepted on the next rising edge.
   task automatic accept(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv);
      @(negedge clk);
      req_valid = 1'b1;
      ed = f;
      a = av;
      b = bv;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic do_muldiv(input string tag, input logic [5:0] f, input logic [31:0] av,
                            input logic [31:0] bv, input logic [31:0] exp_hi,
                            input logic [31:0] exp_lo, input logic exp_dz);
      int n;
      accept(f, av, bv);
      check_eq({tag, " busy"}, 64'(busy), 64'd1);
      check_eq({tag, " ready"}, 64'(req_ready), 64'd0);
      wait_done(n);
      check_eq({tag, " latency"}, 64'(n), 64'd33);
      check_eq({tag, " hi"}, 64'(hi), 64'(exp_hi));
      check_eq({tag, " lo"}, 64'(lo), 64'(exp_lo));
      check_eq({tag, " div_zero"}, 64'(div_zero), 64'(exp_dz));
      @(posedge clk);
      #1;
      check_eq({tag, " done_pulse"}, 64'(done), 64'd0);
      check_eq({tag, " idle"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int n;
      #12;
      check_eq("reset hi", 64'(hi), 64'd0);
      check_eq("reset lo", 64'(lo), 64'd0);
      check_eq("reset busy", 64'(busy), 64'd0);
      check_eq("reset ready", 64'(req_ready), 64'd1);
      check_eq("reset done", 64'(done), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      do_muldiv("mult -9*5", F_MULT, 32'hFFFFFFF7, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFD3, 1'b0);
      do_muldiv("multu -9*5", F_MULTU, 32'hFFFFFFF7, 32'd5, 32'h00000004, 32'hFFFFFFD3, 1'b0);
      do_muldiv("div -9/5", F_DIV, 32'hFFFFFFF7, 32'd5, 32'hFFFFFFFC, 32'hFFFFFFFF, 1'b0);
      do_muldiv("divu -9/5", F_DIVU, 32'hFFFFFFF7, 32'd5, 32'h00000002, 32'h33333331, 1'b0);
      do_muldiv("div 9/-5", F_DIV, 32'd9, 32'hFFFFFFFB, 32'h00000004, 32'hFFFFFFFF, 1'b0);

      accept(F_MTHI, 32'd9, 32'd0);
      check_eq("mthi hi", 64'(hi), 64'd9);
      check_eq("mthi done", 64'(done), 64'd0);
      accept(F_MTLO, 32'd5, 32'd0);
      check_eq("mtlo lo", 64'(lo), 64'd5);
      check_eq("mtlo hi kept", 64'(hi), 64'd9);
      check_eq("mtlo busy", 64'(busy), 64'd0);

      // mthi presented mid-operation must be ignored.
      accept(F_MULT, 32'd3, 32'd4);
      repeat (3) @(posedge clk);
      accept(F_MTHI, 32'hDEADBEEF, 32'd0);
      check_eq("mthi busy ignored", 64'(hi), 64'd9);
      check_eq("mthi busy state", 64'(busy), 64'd1);
      wait_done(n);
      check_eq("mult 3*4 hi", 64'(hi), 64'd0);
      check_eq("mult 3*4 lo", 64'(lo), 64'd12);

      do_muldiv("divu 7/0", F_DIVU, 32'd7, 32'd0, 32'h00000007, 32'hFFFFFFFF, 1'b1);
      accept(F_MULT, 32'd2, 32'd3);
      check_eq("dz cleared", 64'(div_zero), 64'd0);
      wait_done(n);
      check_eq("mult 2*3 lo", 64'(lo), 64'd6);

      do_muldiv("div ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
      do_muldiv("mult min*-1", F_MULT, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);

      // Asynchronous reset mid-multiply discards the operation.
      accept(F_MULT, 32'd100, 32'd7);
      repeat (10) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_eq("rst hi", 64'(hi), 64'd0);
      check_eq("rst lo", 64'(lo), 64'd0);
      check_eq("rst busy", 64'(busy), 64'd0);
      check_eq("rst ready", 64'(req_ready), 64'd1);
      check_eq("rst done", 64'(done), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      req_valid = 1'b1;
      ed = F_MULT;
      a = 32'd3;
      b = 32'd4;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check_eq("post-rst accept", 64'(busy), 64'd1);
      wait_done(n);
      check_eq("post-rst latency", 64'(n), 64'd33);
      check_eq("post-rst lo", 64'(lo), 64'd12);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle multiply/divide responder owning the architectural HI/LO registers. It services the mult/multu/div/divu/mthi/mtlo requests that the pipeline's ALU issues, using the ALU function codes. It exposes HI/LO continuously so the ALU's mfhi/mflo paths read them directly. It sits beside the ALU in the execute stage, and the pipeline stalls on req_ready low.

Parameters:
WIDTH, 32, operand and HI/LO width
ITERS, 32, iterations per mul/div (equals WIDTH)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request strobe
req_ready  out  1  high only in IDLE; a request is accepted on an edge where req_valid && req_ready
ed  in  6  function code: mult 011000, multu 011001, div 011010, divu 011011, mthi 010001, mtlo 010011
a  in  WIDTH  rs operand (multiplicand/dividend/mthi-mtlo data)
b  in  WIDTH  rt operand (multiplier/divisor)
busy  out  1  high while a mul/div is in flight
done  out  1  one-cycle pulse when HI/LO are updated by mul/div
div_zero  out  1  sticky until next accepted mul/div; set when a div/divu with b==0 completes
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (async, any state including mid-operation): state=IDLE, hi=lo=0, done=0, busy=0, div_zero=0, counter=0. The in-flight op is discarded.
- States: IDLE, CALC, FIX.
- IDLE: req_ready=1. On accept:
  - mult/multu/div/divu: latch |a|, |b| (signed ops) or raw a, b (unsigned ops). Latch the result signs. Clear div_zero, counter=0, go to CALC, busy=1.
  - mthi: hi<=a at the accept edge. mtlo: lo<=a at the accept edge. Stay in IDLE, no done pulse.
  - Any other ed value: no effect.
  - req_valid is ignored when req_ready=0.
- CALC, one iteration per cycle:
  - Multiply: radix-2 shift-add on a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract.
  - counter increments each cycle; on the edge where counter==ITERS-1, go to FIX.
- FIX, one cycle:
  - Apply signs. Product sign = sa^sb. Quotient sign = sa^sb. Remainder sign = sa (follows dividend).
  - On the FIX edge: write hi/lo, done<=1, busy<=0, go to IDLE.
  - done clears on the next edge.
- Latency: accept edge = E0; iterations at E1..E32; FIX at E33. New hi/lo and done are visible after E33. busy is high from after E0 through E33. A back-to-back request can be accepted at E34.
- hi/lo hold their old values throughout CALC/FIX. mfhi/mflo issued during busy read stale values, and the pipeline must stall on !req_ready.
- mult/multu: {hi,lo} = full 64-bit product.
- div/divu: lo=quotient, hi=remainder, truncated toward zero.
- Divide by zero: full latency, lo=32'hFFFFFFFF, hi=a (original, unmodified), div_zero=1.
- Overflow: div 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0, no flag.
- Sign handling: magnitude of 0x80000000 is taken as an unsigned 0x80000000. There is no special case.

Decomposition:
- Package muldiv_pkg holds:
  - function-code constants (same values as the ALU's ed_* codes: mult, multu, div, divu, mthi, mtlo, mfhi, mflo);
  - state encoding IDLE/CALC/FIX;
  - WIDTH default.
- Optional sub-module muldiv_iter: the per-cycle shift-add/shift-subtract step, purely combinational, selected by a mul/div bit. The FSM, counter, sign fix and HI/LO registers stay in muldiv_unit.

Test Plan:
- a=-9, b=5, mult → after E33 hi=FFFFFFFF, lo=FFFFFFD3, done pulses 1 cycle. Then multu, same operands → hi=00000004, lo=FFFFFFD3.
- a=-9, b=5, div → lo=FFFFFFFF, hi=FFFFFFFC. divu → lo=33333331, hi=00000002. a=9, b=-5, div → lo=FFFFFFFF, hi=00000004.
- a=9, mthi then a=5, mtlo → hi=9, lo=5 one edge after each accept, no done. Issue mthi while busy → ignored, hi unchanged.
- a=7, b=0, divu → after 33 cycles lo=FFFFFFFF, hi=00000007, div_zero=1. Next mult accept clears div_zero.
- a=80000000, b=FFFFFFFF, div → lo=80000000, hi=0, div_zero=0. mult of the same operands → hi=0, lo=80000000.
- Start mult, assert rst at iteration 10 → immediately hi=lo=0, busy=0, req_ready=1, no done. Request accepted on the first edge after rst deasserts.
